// File: rtl/div_seq_pkg.sv
// Shared definitions for the iterative divider: operand widths, FSM encoding
// and a small conditional-negate helper used by the optional signed path.
package div_seq_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] value,
                                                     input logic             neg);
        return neg ? (~value + 1'b1) : value;
    endfunction

endpackage

// File: rtl/div_seq_adder.sv
// Team adder: WIDTH-bit add/subtract with the carry-out exposed as result[WIDTH].
// In subtract mode result[WIDTH]=1 means opr0 >= opr1 (no borrow).
module div_seq_adder
    import div_seq_pkg::*;
(
    input  logic [WIDTH-1:0] opr0,
    input  logic [WIDTH-1:0] opr1,
    input  logic             minus,
    output logic [WIDTH:0]   result
);

    logic [WIDTH-1:0] opr1_eff;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_inv
            assign opr1_eff[gi] = opr1[gi] ^ minus;
        end
    endgenerate

    assign result = {1'b0, opr0} + {1'b0, opr1_eff} + {{WIDTH{1'b0}}, minus};

endmodule

// File: rtl/div_seq.sv
// Iterative restoring divider, one quotient bit per cycle through a shared adder.
// Optional signed DIV/REM support is enabled by defining SIGNED_DIV_EN.
module div_seq
    import div_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             busy
);

    div_state_t       state_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] r_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [WIDTH:0]   s_shift;
    logic [WIDTH:0]   sub_result;
    logic             take;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] acc_dividend;
    logic [WIDTH-1:0] acc_divisor;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;
    logic             accept;

    assign in_ready = (state_reg == DIV_IDLE);
    assign busy     = (state_reg != DIV_IDLE);
    assign accept   = in_valid && in_ready;

    // The shifted remainder needs a 33rd bit: when it is set, S exceeds any divisor.
    assign s_shift = {r_reg, q_reg[WIDTH-1]};

    div_seq_adder adder0 (
        .opr0   (s_shift[WIDTH-1:0]),
        .opr1   (d_reg),
        .minus  (1'b1),
        .result (sub_result)
    );

    assign take   = s_shift[WIDTH] | sub_result[WIDTH];
    assign r_next = take ? sub_result[WIDTH-1:0] : s_shift[WIDTH-1:0];
    assign q_next = {q_reg[WIDTH-2:0], take};

`ifdef SIGNED_DIV_EN
    logic neg_q_reg;
    logic neg_r_reg;
    logic dividend_neg;
    logic divisor_neg;

    assign dividend_neg = in_signed & in_dividend[WIDTH-1];
    assign divisor_neg  = in_signed & in_divisor[WIDTH-1];
    assign acc_dividend = cond_negate(in_dividend, dividend_neg);
    assign acc_divisor  = cond_negate(in_divisor, divisor_neg);
    assign q_final      = cond_negate(q_next, neg_q_reg);
    assign r_final      = cond_negate(r_next, neg_r_reg);

    // Signs are captured at accept; the core only ever sees magnitudes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
        end else if (accept && !flush) begin
            neg_q_reg <= dividend_neg ^ divisor_neg;
            neg_r_reg <= dividend_neg;
        end
    end
`else
    logic unused_signed;

    assign unused_signed = in_signed;
    assign acc_dividend  = in_dividend;
    assign acc_divisor   = in_divisor;
    assign q_final       = q_next;
    assign r_final       = r_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= DIV_IDLE;
            q_reg         <= '0;
            d_reg         <= '0;
            r_reg         <= '0;
            cnt_reg       <= '0;
            out_valid     <= 1'b0;
            out_quotient  <= '0;
            out_remainder <= '0;
        end else if (flush) begin
            state_reg <= DIV_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state_reg)
                DIV_IDLE: begin
                    if (accept) begin
                        if (in_divisor == '0) begin
                            // Divide by zero skips iteration and reports the raw dividend.
                            state_reg     <= DIV_DONE;
                            out_valid     <= 1'b1;
                            out_quotient  <= '1;
                            out_remainder <= in_dividend;
                        end else begin
                            state_reg <= DIV_CALC;
                            q_reg     <= acc_dividend;
                            d_reg     <= acc_divisor;
                            r_reg     <= '0;
                            cnt_reg   <= CNT_W'(WIDTH - 1);
                        end
                    end
                end
                DIV_CALC: begin
                    q_reg   <= q_next;
                    r_reg   <= r_next;
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == '0) begin
                        state_reg     <= DIV_DONE;
                        out_valid     <= 1'b1;
                        out_quotient  <= q_final;
                        out_remainder <= r_final;
                    end
                end
                DIV_DONE: begin
                    if (out_ready) begin
                        state_reg <= DIV_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= DIV_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq; signed checks engage when SIGNED_DIV_EN is defined.
// Expected results come from Verilog / and % on the operands.
module tb_div_seq;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_dividend;
    logic [31:0] in_divisor;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_quotient;
    logic [31:0] out_remainder;
    logic        busy;

    int     errors;
    int     checks;
    integer seed;

    div_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .in_signed     (in_signed),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain arithmetic on the operands.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                    output logic [31:0] q, output logic [31:0] r);
        logic eff;
`ifdef SIGNED_DIV_EN
        eff = sgn;
`else
        eff = sgn & 1'b0;
`endif
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (eff) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Called #1 after a clock edge with the divider idle. lat = edges after the accept edge
    // until out_valid is seen (0 means visible in the cycle right after accept).
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         output logic [31:0] q, output logic [31:0] r, output int lat);
        in_dividend = a;
        in_divisor  = b;
        in_signed   = sgn;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        q = out_quotient;
        r = out_remainder;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_quotient !== 32'd0) begin errors++; $display("FAIL reset_quotient: got %h expected 0", out_quotient); end
        checks++; if (out_remainder !== 32'd0) begin errors++; $display("FAIL reset_remainder: got %h expected 0", out_remainder); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        $display("reset: out_valid=%b busy=%b in_ready=%b", out_valid, busy, in_ready);
    endtask

    task automatic test_basic();
        logic [31:0] q, r;
        int lat;
        do_op(32'd100, 32'd7, 1'b0, q, r, lat);
        checks++; if (q !== 32'd14) begin errors++; $display("FAIL basic_q: got %0d expected 14", q); end
        checks++; if (r !== 32'd2) begin errors++; $display("FAIL basic_r: got %0d expected 2", r); end
        checks++; if (lat !== 32) begin errors++; $display("FAIL basic_latency: got %0d expected 32", lat); end
        $display("basic: 100/7 -> q=%0d r=%0d latency=%0d", q, r, lat);
        release_result();
    endtask

    task automatic test_div_zero();
        logic [31:0] q, r;
        int lat;
        do_op(32'd5, 32'd0, 1'b0, q, r, lat);
        checks++; if (q !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_q: got %h expected ffffffff", q); end
        checks++; if (r !== 32'd5) begin errors++; $display("FAIL div0_r: got %h expected 5", r); end
        checks++; if (lat !== 0) begin errors++; $display("FAIL div0_latency: got %0d expected 0", lat); end
        $display("div0: 5/0 -> q=%h r=%h latency=%0d", q, r, lat);
        release_result();
    endtask

    task automatic test_signed();
        logic [31:0] q, r;
        logic [31:0] eq1, er1, eq2, er2;
        int lat;
`ifdef SIGNED_DIV_EN
        eq1 = 32'hFFFF_FFFD; er1 = 32'hFFFF_FFFF;
        eq2 = 32'h8000_0000; er2 = 32'd0;
`else
        eq1 = 32'h7FFF_FFFC; er1 = 32'd1;
        eq2 = 32'd0;         er2 = 32'h8000_0000;
`endif
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, q, r, lat);
        checks++; if (q !== eq1) begin errors++; $display("FAIL signed_m7d2_q: got %h expected %h", q, eq1); end
        checks++; if (r !== er1) begin errors++; $display("FAIL signed_m7d2_r: got %h expected %h", r, er1); end
        checks++; if (lat !== 32) begin errors++; $display("FAIL signed_latency: got %0d expected 32", lat); end
        $display("signed: -7/2 -> q=%h r=%h", q, r);
        release_result();
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r, lat);
        checks++; if (q !== eq2) begin errors++; $display("FAIL signed_min_q: got %h expected %h", q, eq2); end
        checks++; if (r !== er2) begin errors++; $display("FAIL signed_min_r: got %h expected %h", r, er2); end
        $display("signed: 80000000/ffffffff -> q=%h r=%h", q, r);
        release_result();
    endtask

    task automatic test_hold();
        logic [31:0] q, r;
        int lat;
        do_op(32'd100, 32'd7, 1'b0, q, r, lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b expected 1", out_valid); end
            checks++; if (out_quotient !== 32'd14) begin errors++; $display("FAIL hold_q: got %0d expected 14", out_quotient); end
            checks++; if (out_remainder !== 32'd2) begin errors++; $display("FAIL hold_r: got %0d expected 2", out_remainder); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready: got %b expected 0", in_ready); end
        end
        // Release with a new request present: it must not be taken in the same cycle.
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_dividend = 32'd9;
        in_divisor  = 32'd3;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_bubble: busy got %b expected 0", busy); end
        $display("hold: 10 stall cycles, release -> in_ready=%b busy=%b", in_ready, busy);
    endtask

    task automatic test_flush();
        logic [31:0] q, r;
        int lat;
        logic seen;
        in_dividend = 32'd1000;
        in_divisor  = 32'd3;
        in_signed   = 1'b0;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_calc_busy: got %b expected 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_calc_ready: got %b expected 1", in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_result: out_valid seen %b expected 0", seen); end
        // Flush beats an accept in IDLE (a divide-by-zero would otherwise finish at once).
        in_dividend = 32'd77;
        in_divisor  = 32'd0;
        in_valid    = 1'b1;
        flush       = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy: got %b expected 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_valid: got %b expected 0", out_valid); end
        // Flush in DONE drops the result.
        do_op(32'd5, 32'd0, 1'b0, q, r, lat);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_done_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_done_ready: got %b expected 1", in_ready); end
        $display("flush: calc/idle/done aborted, busy=%b out_valid=%b", busy, out_valid);
    endtask

    task automatic test_reset_mid();
        in_dividend = 32'd100;
        in_divisor  = 32'd7;
        in_signed   = 1'b0;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
        checks++; if (out_quotient !== 32'd0) begin errors++; $display("FAIL rstmid_q: got %h expected 0", out_quotient); end
        checks++; if (out_remainder !== 32'd0) begin errors++; $display("FAIL rstmid_r: got %h expected 0", out_remainder); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", in_ready); end
        $display("reset_mid: outputs cleared, in_ready=%b", in_ready);
    endtask

    task automatic test_random(input logic sgn, input int n);
        logic [31:0] a, b, q, r, eq, er;
        int lat, sel, elat;
        for (int i = 0; i < n; i++) begin
            a   = $random(seed);
            sel = $random(seed) & 7;
            case (sel)
                0:       b = 32'd0;
                1:       b = $random(seed) & 32'hFF;
                2:       begin b = 32'hFFFF_FFFF; if (i % 2 == 0) a = 32'h8000_0000; end
                3:       b = 32'd1;
                default: b = $random(seed);
            endcase
            ref_div(a, b, sgn, eq, er);
            elat = (b == 32'd0) ? 0 : 32;
            do_op(a, b, sgn, q, r, lat);
            checks++; if (q !== eq) begin errors++; $display("FAIL rand_q: %h/%h s=%b got %h expected %h", a, b, sgn, q, eq); end
            checks++; if (r !== er) begin errors++; $display("FAIL rand_r: %h/%h s=%b got %h expected %h", a, b, sgn, r, er); end
            checks++; if (lat !== elat) begin errors++; $display("FAIL rand_latency: %h/%h got %0d expected %0d", a, b, lat, elat); end
            $display("rand s=%b: %h/%h -> q=%h r=%h", sgn, a, b, q, r);
            release_result();
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        seed        = 5;
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_dividend = 32'd0;
        in_divisor  = 32'd0;
        in_signed   = 1'b0;
        out_ready   = 1'b0;
        test_reset();
        test_basic();
        test_div_zero();
        test_signed();
        test_hold();
        test_flush();
        test_reset_mid();
        test_random(1'b0, 600);
        test_random(1'b1, 600);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
